l15_req_arbiter: RTL
====================

Name: l15_req_arbiter

Overview:
- Shares the single L1.5 request port between three requesters: icache miss (src 0), dcache load miss (src 1) and dcache write-buffer store (src 2).
- Allocates a per-source transaction ID (TID) for each request, enforces outstanding-request limits, and routes L1.5 responses back to the owning source by {src, tid}.
- Provides a drain/flush handshake so the cache controllers can quiesce the memory interface before fence or flush.
- Sits between the write-through cache subsystem and the L1.5 adapter.

Parameters:
- NumSrc, 3, number of requesters; fixed order icache, dcache load, dcache store.
- TidWidth, 3, TID width; 2**TidWidth TIDs per source.
- AddrWidth, 64, request address width.
- DataWidth, 64, store data width.
- MaxOutStores, 7, outstanding-request cap for src 2; must be ≤ 2**TidWidth.
- StoreSrc, 2, index of the store source.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  NumSrc  per-source request valid.
- req_ready_o  out  NumSrc  per-source accept; a request transfers when valid & ready.
- req_addr_i  in  NumSrc*AddrWidth  per-source address, flattened, src 0 in the LSBs.
- req_data_i  in  NumSrc*DataWidth  per-source store data.
- req_size_i  in  NumSrc*3  per-source log2 byte size.
- req_nc_i  in  NumSrc  non-cacheable flag.
- req_tid_o  out  TidWidth  TID assigned to the accepted request; valid in the cycle of acceptance.
- mem_valid_o  out  1  L1.5 request valid.
- mem_ready_i  in  1  L1.5 request ready.
- mem_src_o  out  2  source of the L1.5 request.
- mem_tid_o  out  TidWidth  TID of the L1.5 request.
- mem_addr_o  out  AddrWidth  address.
- mem_data_o  out  DataWidth  data.
- mem_size_o  out  3  size.
- mem_nc_o  out  1  non-cacheable flag.
- rsp_valid_i  in  1  L1.5 response valid; always accepted.
- rsp_src_i  in  2  response source.
- rsp_tid_i  in  TidWidth  response TID.
- rsp_valid_o  out  NumSrc  one-hot routed response strobe.
- rsp_tid_o  out  TidWidth  TID of the routed response.
- flush_i  in  1  drain request, level.
- flush_done_o  out  1  single-cycle pulse when the drain completes.
- spurious_o  out  1  single-cycle pulse on a response to an unallocated TID.

Behaviour:
- Reset (async, rst_i=1):
  - all outputs 0; TID bitmaps cleared; store counter 0; RR pointer 0; FSM=IDLE.
  - Any in-flight request is dropped without a response.
- Per-source eligibility: req_valid_i[s] & a free TID exists in tidmap[s] & (s≠StoreSrc | store_cnt<MaxOutStores) & FSM=IDLE & !flush_i.
- Arbitration: round-robin among eligible sources, starting at the RR pointer. On grant the pointer becomes (granted+1) mod NumSrc; otherwise it is unchanged.
- FSM:
  - IDLE: at most one req_ready_o is high, combinationally, for the granted source.
    - On transfer: capture the payload into the output register, allocate the lowest free TID of tidmap[s] (from the registered bitmap), drive req_tid_o=that TID, set the bit, increment store_cnt if s=StoreSrc, go to SEND.
  - SEND: mem_valid_o=1 with registered fields held stable; all req_ready_o=0.
    - mem_ready_i=1 → IDLE, mem_valid_o=0 next cycle.
    - A new grant is possible in the next IDLE cycle, giving 1 request per 2 cycles maximum.
  - DRAIN: entered from IDLE when flush_i=1.
    - Stay until all tidmaps are 0 and store_cnt=0, then pulse flush_done_o and go to IDLE.
    - If flush_i is still high after the pulse, re-enter DRAIN with an immediate pulse when already empty. Requesters must drop flush_i after done.
    - flush_i asserted during SEND: finish SEND first, then enter DRAIN.
- Latency: acceptance to mem_valid_o = 1 cycle.
- Responses:
  - rsp_valid_i with tidmap[rsp_src_i][rsp_tid_i]=1:
    - rsp_valid_o[src]=1 and rsp_tid_o=rsp_tid_i in the same cycle (combinational).
    - Clear the bit; decrement store_cnt if src=StoreSrc.
  - Unallocated TID or src≥NumSrc: no rsp_valid_o, no state change, spurious_o=1 for that cycle.
  - A response and an allocation for the same source in the same cycle:
    - the counter is net unchanged;
    - the freed TID is not reallocated that cycle, because allocation uses the pre-update bitmap.
- store_cnt never wraps: it saturates by construction, since no grant is issued at the cap.

Test Plan:
- Single icache request at addr 0x8000_0040 with mem_ready_i held 1 → req_tid_o=0, mem_valid_o high next cycle with src=0, tid=0, addr echoed; response {0,0} → rsp_valid_o=3'b001.
- All three sources valid continuously, mem_ready_i=1 → grant order 0,1,2,0,1,2; TIDs 0,0,0,1,1,1.
- Store source issues 8 requests with no responses → 7 accepted (TIDs 0-6), 8th stalls with req_ready_o[2]=0; one response {2,3} → next store gets TID 3.
- mem_ready_i held 0 for 5 cycles during SEND → mem_* fields stable, all req_ready_o=0, no second grant.
- flush_i raised with 2 loads outstanding → no grants; flush_done_o pulses exactly 1 cycle after the second response.
- Response {1,5} with no TID allocated → spurious_o=1, rsp_valid_o=0; rst_i pulsed mid-SEND → mem_valid_o=0 immediately and all bitmaps cleared.

Source files
------------

// File: rtl/l15_req_arbiter_if.sv
// l15_req_arbiter_if: requester, L1.5 request, L1.5 response and drain
// signals shared between the cache subsystem and the L1.5 arbiter.
interface l15_req_arbiter_if #(
    parameter int NumSrc    = 3,
    parameter int TidWidth  = 3,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
);
    logic [NumSrc-1:0]           req_valid_i;
    logic [NumSrc-1:0]           req_ready_o;
    logic [NumSrc*AddrWidth-1:0] req_addr_i;
    logic [NumSrc*DataWidth-1:0] req_data_i;
    logic [NumSrc*3-1:0]         req_size_i;
    logic [NumSrc-1:0]           req_nc_i;
    logic [TidWidth-1:0]         req_tid_o;

    logic                        mem_valid_o;
    logic                        mem_ready_i;
    logic [1:0]                  mem_src_o;
    logic [TidWidth-1:0]         mem_tid_o;
    logic [AddrWidth-1:0]        mem_addr_o;
    logic [DataWidth-1:0]        mem_data_o;
    logic [2:0]                  mem_size_o;
    logic                        mem_nc_o;

    logic                        rsp_valid_i;
    logic [1:0]                  rsp_src_i;
    logic [TidWidth-1:0]         rsp_tid_i;
    logic [NumSrc-1:0]           rsp_valid_o;
    logic [TidWidth-1:0]         rsp_tid_o;

    logic                        flush_i;
    logic                        flush_done_o;
    logic                        spurious_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_size_i, req_nc_i,
        output req_ready_o, req_tid_o,
        output mem_valid_o, mem_src_o, mem_tid_o, mem_addr_o,
        output mem_data_o, mem_size_o, mem_nc_o,
        input  mem_ready_i,
        input  rsp_valid_i, rsp_src_i, rsp_tid_i,
        output rsp_valid_o, rsp_tid_o,
        input  flush_i,
        output flush_done_o, spurious_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_size_i, req_nc_i,
        input  req_ready_o, req_tid_o,
        input  mem_valid_o, mem_src_o, mem_tid_o, mem_addr_o,
        input  mem_data_o, mem_size_o, mem_nc_o,
        output mem_ready_i,
        output rsp_valid_i, rsp_src_i, rsp_tid_i,
        input  rsp_valid_o, rsp_tid_o,
        output flush_i,
        input  flush_done_o, spurious_o
    );
endinterface

// File: rtl/l15_req_arbiter.sv
// l15_req_arbiter: round-robin share of the L1.5 request port between icache,
// dcache load and store sources, with per-source TIDs and a drain handshake.
module l15_req_arbiter #(
    parameter int NumSrc       = 3,
    parameter int TidWidth     = 3,
    parameter int AddrWidth    = 64,
    parameter int DataWidth    = 64,
    parameter int MaxOutStores = 7,
    parameter int StoreSrc     = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    l15_req_arbiter_if.slave bus
);

    localparam int NumTid = 2 ** TidWidth;
    localparam int CntW   = $clog2(MaxOutStores + 1);
    localparam logic [CntW-1:0] StoreCap = CntW'(MaxOutStores);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NumSrc-1:0][NumTid-1:0]   tidmap, tidmap_nxt;
    logic [CntW-1:0]                 store_cnt, cnt_nxt;
    logic [1:0]                      rr_ptr, rr_nxt;

    logic [NumSrc-1:0]               has_free;
    logic [NumSrc-1:0][TidWidth-1:0] free_tid;
    logic                            store_ok;
    logic [NumSrc-1:0]               elig;
    logic [NumSrc-1:0]               gnt;
    logic                            gnt_any;
    logic [1:0]                      gnt_idx;

    logic [TidWidth-1:0]             sel_tid;
    logic [AddrWidth-1:0]            sel_addr;
    logic [DataWidth-1:0]            sel_data;
    logic [2:0]                      sel_size;
    logic                            sel_nc;

    logic [NumSrc-1:0]               rsp_hit;
    logic                            all_empty;
    logic                            flush_done;

    logic [1:0]                      src_q;
    logic [TidWidth-1:0]             tid_q;
    logic [AddrWidth-1:0]            addr_q;
    logic [DataWidth-1:0]            data_q;
    logic [2:0]                      size_q;
    logic                            nc_q;

    function automatic logic [TidWidth-1:0] lowest_free(
        input logic [NumTid-1:0] m
    );
        logic [TidWidth-1:0] r;
        r = '0;
        for (int t = NumTid - 1; t >= 0; t--) begin
            if (!m[t]) r = TidWidth'(t);
        end
        return r;
    endfunction

    always_comb begin
        has_free = '0;
        free_tid = '0;
        for (int s = 0; s < NumSrc; s++) begin
            has_free[s] = ~&tidmap[s];
            free_tid[s] = lowest_free(tidmap[s]);
        end
    end

    assign store_ok = store_cnt < StoreCap;

    always_comb begin
        elig = '0;
        for (int s = 0; s < NumSrc; s++) begin
            elig[s] = bus.req_valid_i[s] & has_free[s]
                    & ((s != StoreSrc) | store_ok)
                    & (state == IDLE) & ~bus.flush_i & ~rst_i;
        end
    end

    // Scan starts at the RR pointer so the last winner goes to the back.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int i = 0; i < NumSrc; i++) begin
            int s;
            s = (int'(rr_ptr) + i) % NumSrc;
            if (!gnt_any && elig[s]) begin
                gnt_any = 1'b1;
                gnt_idx = 2'(s);
                gnt[s]  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_tid  = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_size = '0;
        sel_nc   = 1'b0;
        for (int s = 0; s < NumSrc; s++) begin
            if (gnt[s]) begin
                sel_tid  = free_tid[s];
                sel_addr = bus.req_addr_i[s*AddrWidth +: AddrWidth];
                sel_data = bus.req_data_i[s*DataWidth +: DataWidth];
                sel_size = bus.req_size_i[s*3 +: 3];
                sel_nc   = bus.req_nc_i[s];
            end
        end
    end

    always_comb begin
        rsp_hit = '0;
        for (int s = 0; s < NumSrc; s++) begin
            rsp_hit[s] = bus.rsp_valid_i & ~rst_i
                       & (bus.rsp_src_i == 2'(s))
                       & tidmap[s][bus.rsp_tid_i];
        end
    end

    // Allocation reads the registered map, so a TID freed this cycle
    // is only reusable next cycle.
    always_comb begin
        tidmap_nxt = tidmap;
        for (int s = 0; s < NumSrc; s++) begin
            if (rsp_hit[s]) tidmap_nxt[s][bus.rsp_tid_i] = 1'b0;
            if (gnt[s])     tidmap_nxt[s][free_tid[s]]   = 1'b1;
        end
        cnt_nxt = store_cnt
                + CntW'(gnt[StoreSrc])
                - CntW'(rsp_hit[StoreSrc]);
    end

    always_comb begin
        rr_nxt = rr_ptr;
        if (gnt_any) begin
            rr_nxt = (gnt_idx == 2'(NumSrc - 1)) ? 2'd0 : gnt_idx + 2'd1;
        end
    end

    assign all_empty = ~|tidmap && (store_cnt == '0);

    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.flush_i)  state_nxt = DRAIN;
                else if (gnt_any) state_nxt = SEND;
            end
            SEND: begin
                if (bus.mem_ready_i) state_nxt = bus.flush_i ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (all_empty) begin
                    flush_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            tidmap    <= '0;
            store_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            tidmap    <= tidmap_nxt;
            store_cnt <= cnt_nxt;
            rr_ptr    <= rr_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q  <= '0;
            tid_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            size_q <= '0;
            nc_q   <= 1'b0;
        end else if (gnt_any) begin
            src_q  <= gnt_idx;
            tid_q  <= sel_tid;
            addr_q <= sel_addr;
            data_q <= sel_data;
            size_q <= sel_size;
            nc_q   <= sel_nc;
        end
    end

    assign bus.req_ready_o  = gnt;
    assign bus.req_tid_o    = sel_tid;

    assign bus.mem_valid_o  = (state == SEND);
    assign bus.mem_src_o    = src_q;
    assign bus.mem_tid_o    = tid_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_data_o   = data_q;
    assign bus.mem_size_o   = size_q;
    assign bus.mem_nc_o     = nc_q;

    assign bus.rsp_valid_o  = rsp_hit;
    assign bus.rsp_tid_o    = (|rsp_hit) ? bus.rsp_tid_i : '0;
    assign bus.spurious_o   = bus.rsp_valid_i & ~rst_i & ~|rsp_hit;
    assign bus.flush_done_o = flush_done;

    a_onehot_grant: assert property (
        @(posedge clk_i) disable iff (rst_i) $onehot0(gnt)
    );

    a_store_cap: assert property (
        @(posedge clk_i) disable iff (rst_i) store_cnt <= StoreCap
    );

endmodule
